// File: rtl/cim_xbar_rx_if.sv
// Write-side bus between the input controller and the crossbar receiver.
// The controller (master) streams one element per tile per write cycle and
// waits on busy; the receiver (slave) presents captured vectors until acked.
interface cim_xbar_rx_if #(
  parameter int datatype_size = 8,
  parameter int input_size    = 201,
  parameter int xbar_size     = 256,
  parameter int v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size
);
  logic                                                  i_cim_we;
  logic [v_cim_tiles-1:0][datatype_size-1:0]             i_data;
  logic                                                  o_cim_busy;
  logic                                                  o_valid;
  logic                                                  i_ack;
  logic [v_cim_tiles*xbar_size-1:0][datatype_size-1:0]   o_data;
  logic                                                  o_overrun;

  modport master (
    output i_cim_we, i_data, i_ack,
    input  o_cim_busy, o_valid, o_data, o_overrun
  );

  modport slave (
    input  i_cim_we, i_data, i_ack,
    output o_cim_busy, o_valid, o_data, o_overrun
  );
endinterface

// File: rtl/cim_xbar_rx.sv
// Crossbar-side receiver: assembles one input vector per tile from a stream
// of per-tile elements, holds busy through a fixed compute window, then
// presents the captured vectors until the output stage acknowledges them.
module cim_xbar_rx #(
  parameter int datatype_size  = 8,
  parameter int input_size     = 201,
  parameter int xbar_size      = 256,
  parameter int compute_cycles = 4,
  parameter int v_cim_tiles    = (input_size + xbar_size - 1) / xbar_size
) (
  input  logic           clk,
  input  logic           rst,
  cim_xbar_rx_if.slave   bus
);
  // A single tile only needs input_size rows; multiple tiles fill every row.
  localparam int count_limit = (v_cim_tiles > 1) ? xbar_size : input_size;
  localparam int n_entries   = v_cim_tiles * xbar_size;
  localparam int aw          = $clog2(count_limit + 1);
  localparam logic [aw-1:0] last_addr = aw'(count_limit - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMPUTE, HOLD} state_t;

  state_t                                       state_q, state_d;
  logic [aw-1:0]                                wr_addr_q, wr_addr_d;
  logic [aw-1:0]                                wr_idx;
  logic [7:0]                                   cnt_q, cnt_d;
  logic                                         busy_q, busy_d;
  logic                                         valid_q, valid_d;
  logic                                         overrun_q, overrun_d;
  logic [n_entries-1:0][datatype_size-1:0]      data_q, data_d;
  logic [v_cim_tiles-1:0][datatype_size-1:0]    wr_val;
  logic                                         wr_en;

  // The first write of a transfer always lands on row 0 from IDLE.
  assign wr_idx = (state_q == FILL) ? wr_addr_q : '0;
  assign wr_en  = bus.i_cim_we && ((state_q == IDLE) || (state_q == FILL));

  // Rows past the last valid element of the final tile are zero-padded.
  generate
    for (genvar gi = 0; gi < v_cim_tiles; gi++) begin : g_pad
      assign wr_val[gi] = ((gi * xbar_size + int'(wr_idx)) < input_size) ?
                          bus.i_data[gi] : '0;
    end
  endgenerate

  // Next-state, counters and registered handshake outputs.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    overrun_d = overrun_q |
                (bus.i_cim_we && ((state_q == COMPUTE) || (state_q == HOLD)));
    case (state_q)
      IDLE, FILL: begin
        if (bus.i_cim_we) begin
          if (wr_idx == last_addr) begin
            state_d   = COMPUTE;
            wr_addr_d = '0;
            cnt_d     = 8'(compute_cycles);
            busy_d    = 1'b1;
          end else begin
            state_d   = FILL;
            wr_addr_d = wr_idx + 1'b1;
          end
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.i_ack) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the current element of every tile into its row.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      for (int t = 0; t < v_cim_tiles; t++) begin
        data_d[t * xbar_size + int'(wr_idx)] = wr_val[t];
      end
    end
  end

  // State registers; reset clears everything, including captured vectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

  assign bus.o_cim_busy = busy_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_overrun  = overrun_q;
  assign bus.o_data     = data_q;
endmodule

// File: tb/tb_cim_xbar_rx.sv
// Bench for cim_xbar_rx: a single-tile instance (201/256) and a two-tile
// instance (300/256) driven by directed transfers with random data/stalls.
module tb_cim_xbar_rx;
  localparam int IN_A = 201;
  localparam int CC_A = 4;
  localparam int IN_B = 300;
  localparam int CC_B = 3;
  localparam int XB   = 256;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [7:0] exp_a [XB];
  logic [7:0] exp_b [2*XB];

  cim_xbar_rx_if #(.datatype_size(8), .input_size(IN_A), .xbar_size(XB)) bus_a ();
  cim_xbar_rx_if #(.datatype_size(8), .input_size(IN_B), .xbar_size(XB)) bus_b ();

  cim_xbar_rx #(.datatype_size(8), .input_size(IN_A), .xbar_size(XB),
                .compute_cycles(CC_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  cim_xbar_rx #(.datatype_size(8), .input_size(IN_B), .xbar_size(XB),
                .compute_cycles(CC_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_check_data(input string tag);
    for (int i = 0; i < XB; i++) chk(tag, 32'(bus_a.o_data[i]), 32'(exp_a[i]));
  endtask

  task automatic a_ack();
    bus_a.i_ack = 1'b1;
    tick();
    chk("a_ack_busy", 32'(bus_a.o_cim_busy), 0);
    chk("a_ack_valid", 32'(bus_a.o_valid), 0);
    bus_a.i_ack = 1'b0;
  endtask

  // One full transfer on instance A: optional stall burst before element
  // stall_after, then the compute window; ends with the DUT in HOLD.
  task automatic a_transfer(input int stall_after, input int stall_len, input bit rnd);
    int k;
    int stalls;
    logic [7:0] d;
    k = 0;
    stalls = stall_len;
    while (k < IN_A) begin
      if (k == stall_after && stalls > 0) begin
        bus_a.i_cim_we = 1'b0;
        stalls--;
      end else begin
        d = rnd ? 8'($urandom) : 8'(k);
        bus_a.i_cim_we = 1'b1;
        bus_a.i_data[0] = d;
        exp_a[k] = d;
        k++;
      end
      tick();
      if (k < IN_A) begin
        chk("a_fill_busy", 32'(bus_a.o_cim_busy), 0);
        chk("a_fill_valid", 32'(bus_a.o_valid), 0);
      end
    end
    bus_a.i_cim_we = 1'b0;
    chk("a_busy_after_last", 32'(bus_a.o_cim_busy), 1);
    chk("a_valid_after_last", 32'(bus_a.o_valid), 0);
    for (int i = 1; i < CC_A; i++) begin
      tick();
      chk("a_compute_busy", 32'(bus_a.o_cim_busy), 1);
      chk("a_compute_valid", 32'(bus_a.o_valid), 0);
    end
    tick();
    chk("a_hold_busy", 32'(bus_a.o_cim_busy), 1);
    chk("a_hold_valid", 32'(bus_a.o_valid), 1);
    a_check_data("a_data");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < XB; i++) exp_a[i] = 8'h00;
    for (int i = 0; i < 2*XB; i++) exp_b[i] = 8'h00;
    rst = 1'b0;
    bus_a.i_cim_we = 1'b0; bus_a.i_ack = 1'b0; bus_a.i_data = '0;
    bus_b.i_cim_we = 1'b0; bus_b.i_ack = 1'b0; bus_b.i_data = '0;

    // Reset state
    #12;
    chk("rst_a_busy", 32'(bus_a.o_cim_busy), 0);
    chk("rst_a_valid", 32'(bus_a.o_valid), 0);
    chk("rst_a_overrun", 32'(bus_a.o_overrun), 0);
    chk("rst_b_busy", 32'(bus_b.o_cim_busy), 0);
    chk("rst_b_valid", 32'(bus_b.o_valid), 0);
    a_check_data("rst_a_data");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Index stream, no stalls
    a_transfer(-1, 0, 1'b0);
    a_ack();

    // Back-to-back: same stream starts the cycle after ack, 3-cycle stall
    a_transfer(100, 3, 1'b0);
    chk("a_overrun_clear", 32'(bus_a.o_overrun), 0);

    // HOLD with a stray write and no ack for 10 cycles
    for (int i = 0; i < 10; i++) begin
      bus_a.i_cim_we = (i == 4);
      bus_a.i_data[0] = 8'($urandom);
      tick();
      chk("hold_busy", 32'(bus_a.o_cim_busy), 1);
      chk("hold_valid", 32'(bus_a.o_valid), 1);
      chk("hold_overrun", 32'(bus_a.o_overrun), (i >= 4) ? 1 : 0);
    end
    bus_a.i_cim_we = 1'b0;
    a_check_data("hold_data");

    // Ack and write together in HOLD: ack wins, write dropped
    bus_a.i_ack = 1'b1;
    bus_a.i_cim_we = 1'b1;
    bus_a.i_data[0] = 8'h5a;
    tick();
    bus_a.i_ack = 1'b0;
    bus_a.i_cim_we = 1'b0;
    chk("ackwe_busy", 32'(bus_a.o_cim_busy), 0);
    chk("ackwe_valid", 32'(bus_a.o_valid), 0);
    a_check_data("ackwe_data");
    tick();

    // Random data with a random stall burst
    a_transfer(int'($urandom_range(1, IN_A - 2)), int'($urandom_range(1, 5)), 1'b1);
    a_ack();

    // Asynchronous reset in the middle of a transfer
    for (int k = 0; k < 150; k++) begin
      bus_a.i_cim_we = 1'b1;
      bus_a.i_data[0] = 8'($urandom);
      tick();
    end
    chk("a_overrun_before_rst", 32'(bus_a.o_overrun), 1);
    #2;
    rst = 1'b0;
    bus_a.i_cim_we = 1'b0;
    #1;
    chk("arst_busy", 32'(bus_a.o_cim_busy), 0);
    chk("arst_valid", 32'(bus_a.o_valid), 0);
    chk("arst_overrun", 32'(bus_a.o_overrun), 0);
    for (int i = 0; i < XB; i++) exp_a[i] = 8'h00;
    a_check_data("arst_data");
    @(negedge clk);
    rst = 1'b1;
    tick();
    a_transfer(-1, 0, 1'b1);
    a_ack();

    // Two tiles: tile0 = index, tile1 = index+1, padding past element 300
    chk("b_overrun0", 32'(bus_b.o_overrun), 0);
    for (int k = 0; k < XB; k++) begin
      bus_b.i_cim_we = 1'b1;
      bus_b.i_data[0] = 8'(k);
      bus_b.i_data[1] = 8'(k + 1);
      exp_b[k] = 8'(k);
      exp_b[XB + k] = (XB + k < IN_B) ? 8'(k + 1) : 8'h00;
      tick();
      if (k < XB - 1) chk("b_fill_busy", 32'(bus_b.o_cim_busy), 0);
    end
    bus_b.i_cim_we = 1'b0;
    chk("b_busy_after_last", 32'(bus_b.o_cim_busy), 1);
    chk("b_valid_after_last", 32'(bus_b.o_valid), 0);
    for (int i = 1; i < CC_B; i++) begin
      tick();
      chk("b_compute_valid", 32'(bus_b.o_valid), 0);
    end
    tick();
    chk("b_hold_valid", 32'(bus_b.o_valid), 1);
    chk("b_hold_busy", 32'(bus_b.o_cim_busy), 1);
    for (int i = 0; i < 2*XB; i++) chk("b_data", 32'(bus_b.o_data[i]), 32'(exp_b[i]));
    bus_b.i_ack = 1'b1;
    tick();
    bus_b.i_ack = 1'b0;
    chk("b_ack_busy", 32'(bus_b.o_cim_busy), 0);
    chk("b_ack_valid", 32'(bus_b.o_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
